// File: rtl/pong_score_keeper.sv
// rtl/pong_score_keeper.sv - pong match state: scores, serve timing, winner latch
//
// Tracks both players' points, freezes the ball after each point, releases it
// with a one-cycle serve pulse after SERVE_FRAMES frame ticks, and latches a
// winner once either score reaches WIN_SCORE.
//
// Ports:
//   clk         in   pixel clock
//   reset       in   synchronous active-high reset
//   frame_tick  in   one-cycle pulse per frame
//   goal_p1     in   player 1 scored (rising edge counts once)
//   goal_p2     in   player 2 scored (rising edge counts once)
//   new_game    in   restart request (rising edge)
//   score_p1    out  player 1 points, 0..WIN_SCORE
//   score_p2    out  player 2 points, 0..WIN_SCORE
//   ball_freeze out  hold ball at centre
//   serve       out  one-cycle ball release pulse
//   serve_dir   out  0 = toward player 1, 1 = toward player 2
//   game_over   out  winner latched
//   winner      out  00 none, 01 player 1, 10 player 2

module pong_score_keeper #(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       goal_p1,
    input  logic       goal_p2,
    input  logic       new_game,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       ball_freeze,
    output logic       serve,
    output logic       serve_dir,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [3:0] WIN_LIMIT  = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [3:0] score_p1_q, score_p1_d;
    logic [3:0] score_p2_q, score_p2_d;
    logic       ball_freeze_q, ball_freeze_d;
    logic       serve_q, serve_d;
    logic       serve_dir_q, serve_dir_d;
    logic       game_over_q, game_over_d;
    logic [1:0] winner_q, winner_d;
    logic       goal_p1_q, goal_p2_q, new_game_q;

    logic goal_p1_ev, goal_p2_ev, new_game_ev;
    logic serve_now;
    logic p1_reaches_win, p2_reaches_win;

    assign goal_p1_ev  = goal_p1 & ~goal_p1_q;
    assign goal_p2_ev  = goal_p2 & ~goal_p2_q;
    assign new_game_ev = new_game & ~new_game_q;

    assign serve_now      = (state_q == ST_WAIT) && frame_tick && (frame_cnt_q == SERVE_LAST);
    assign p1_reaches_win = (score_p1_q + 4'd1) == WIN_LIMIT;
    assign p2_reaches_win = (score_p2_q + 4'd1) == WIN_LIMIT;

    // State register plus all registered outputs and edge-detect copies.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_WAIT;
            frame_cnt_q   <= 8'd0;
            score_p1_q    <= 4'd0;
            score_p2_q    <= 4'd0;
            ball_freeze_q <= 1'b1;
            serve_q       <= 1'b0;
            serve_dir_q   <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= 2'b00;
            goal_p1_q     <= 1'b0;
            goal_p2_q     <= 1'b0;
            new_game_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            score_p1_q    <= score_p1_d;
            score_p2_q    <= score_p2_d;
            ball_freeze_q <= ball_freeze_d;
            serve_q       <= serve_d;
            serve_dir_q   <= serve_dir_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
            goal_p1_q     <= goal_p1;
            goal_p2_q     <= goal_p2;
            new_game_q    <= new_game;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (new_game_ev) begin
            state_d = ST_WAIT;
        end else begin
            case (state_q)
                ST_WAIT: if (serve_now) state_d = ST_PLAY;
                ST_PLAY: begin
                    if (goal_p1_ev && goal_p2_ev) begin
                        state_d = ST_WAIT;
                    end else if (goal_p1_ev) begin
                        state_d = p1_reaches_win ? ST_OVER : ST_WAIT;
                    end else if (goal_p2_ev) begin
                        state_d = p2_reaches_win ? ST_OVER : ST_WAIT;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Output / datapath logic. ball_freeze and game_over follow the next
    // state so they change on the same edge as the state itself.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        serve_d     = 1'b0;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;

        if (new_game_ev) begin
            frame_cnt_d = 8'd0;
            score_p1_d  = 4'd0;
            score_p2_d  = 4'd0;
            serve_dir_d = 1'b0;
            winner_d    = 2'b00;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (serve_now) begin
                        serve_d     = 1'b1;
                        frame_cnt_d = 8'd0;
                    end else if (frame_tick) begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
                ST_PLAY: begin
                    // Counter is cleared on every exit so WAIT always starts at 0;
                    // a tick on the exit edge is therefore not counted.
                    frame_cnt_d = 8'd0;
                    if (goal_p1_ev && !goal_p2_ev) begin
                        score_p1_d  = score_p1_q + 4'd1;
                        serve_dir_d = 1'b1;
                        if (p1_reaches_win) winner_d = 2'b01;
                    end else if (goal_p2_ev && !goal_p1_ev) begin
                        score_p2_d  = score_p2_q + 4'd1;
                        serve_dir_d = 1'b0;
                        if (p2_reaches_win) winner_d = 2'b10;
                    end
                end
                default: ;
            endcase
        end

        ball_freeze_d = (state_d != ST_PLAY);
        game_over_d   = (state_d == ST_OVER);
    end

    assign score_p1    = score_p1_q;
    assign score_p2    = score_p2_q;
    assign ball_freeze = ball_freeze_q;
    assign serve       = serve_q;
    assign serve_dir   = serve_dir_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// tb/tb_pong_score_keeper.sv - randomized and directed bench for pong_score_keeper
module tb_pong_score_keeper;

    localparam int WIN = 9;
    localparam int SF  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       goal_p1 = 1'b0;
    logic       goal_p2 = 1'b0;
    logic       new_game = 1'b0;
    logic [3:0] score_p1, score_p2;
    logic       ball_freeze, serve, serve_dir, game_over;
    logic [1:0] winner;

    pong_score_keeper #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .goal_p1(goal_p1), .goal_p2(goal_p2), .new_game(new_game),
        .score_p1(score_p1), .score_p2(score_p2), .ball_freeze(ball_freeze),
        .serve(serve), .serve_dir(serve_dir), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phase 0 = waiting to serve, 1 = rally, 2 = match over.
    int m_phase, m_ticks, m_s1, m_s2, m_win;
    bit m_serve, m_dir;
    bit p_g1, p_g2, p_ng;

    task automatic model(input bit rst, input bit ft, input bit g1, input bit g2, input bit ng);
        bit e1, e2, en;
        e1 = g1 && !p_g1;
        e2 = g2 && !p_g2;
        en = ng && !p_ng;
        m_serve = 0;
        if (rst) begin
            m_phase = 0; m_ticks = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0;
            p_g1 = 0; p_g2 = 0; p_ng = 0;
            return;
        end
        if (en) begin
            m_phase = 0; m_ticks = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0;
        end else if (m_phase == 0) begin
            if (ft) begin
                m_ticks++;
                if (m_ticks == SF) begin
                    m_phase = 1; m_ticks = 0; m_serve = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (e1 && e2) begin
                m_phase = 0; m_ticks = 0;
            end else if (e1 || e2) begin
                if (e1) begin m_s1++; m_dir = 1; end
                else    begin m_s2++; m_dir = 0; end
                if (m_s1 == WIN)      begin m_phase = 2; m_win = 1; end
                else if (m_s2 == WIN) begin m_phase = 2; m_win = 2; end
                else                  begin m_phase = 0; m_ticks = 0; end
            end
        end
        p_g1 = g1; p_g2 = g2; p_ng = ng;
    endtask

    task automatic compare_all();
        check("score_p1",    8'(score_p1),    8'(m_s1));
        check("score_p2",    8'(score_p2),    8'(m_s2));
        check("ball_freeze", 8'(ball_freeze), 8'(m_phase != 1));
        check("serve",       8'(serve),       8'(m_serve));
        check("serve_dir",   8'(serve_dir),   8'(m_dir));
        check("game_over",   8'(game_over),   8'(m_phase == 2));
        check("winner",      8'(winner),      8'(m_win));
    endtask

    task automatic step(input bit rst, input bit ft, input bit g1, input bit g2, input bit ng);
        @(negedge clk);
        reset = rst; frame_tick = ft; goal_p1 = g1; goal_p2 = g2; new_game = ng;
        @(posedge clk);
        model(rst, ft, g1, g2, ng);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    // SF ticks separated by idle cycles; the serve pulse follows the last one.
    task automatic serve_wait();
        for (int i = 0; i < SF; i++) begin
            step(0, 1, 0, 0, 0);
            if (i < SF - 1) idle();
        end
    endtask

    initial begin
        // Reset and first serve.
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1);
        check("reset_freeze", 8'(ball_freeze), 8'd1);
        idle();
        serve_wait();
        check("first_serve", 8'(serve), 8'd1);
        idle();
        check("serve_one_cycle", 8'(serve), 8'd0);
        check("play_unfrozen", 8'(ball_freeze), 8'd0);

        // Held goal scores once.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
        idle();
        check("held_goal_p2", 8'(score_p2), 8'd1);
        serve_wait();
        idle();

        // Simultaneous goals: re-serve, no score change.
        step(0, 0, 1, 1, 0);
        check("both_goals_freeze", 8'(ball_freeze), 8'd1);
        idle();
        serve_wait();
        idle();

        // Player 1 wins, one point per rally.
        for (int r = 0; r < WIN; r++) begin
            step(0, 0, 1, 0, 0);
            idle();
            if (r < WIN - 1) begin
                serve_wait();
                idle();
            end
        end
        check("win_score_p1", 8'(score_p1), 8'(WIN));
        check("win_winner", 8'(winner), 8'd1);
        for (int i = 0; i < 8; i++) step(0, i[0], i[1], !i[1], 0);
        check("over_hold_p2", 8'(score_p2), 8'd1);

        // new_game beats a simultaneous goal.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        check("ng_over_goal_p2", 8'(score_p2), 8'd0);
        check("ng_game_over", 8'(game_over), 8'd0);
        step(0, 0, 0, 0, 0);

        // Reset in the serve cycle drops the serve.
        serve_wait();
        step(1, 0, 0, 0, 0);
        check("reset_mid_serve", 8'(serve), 8'd0);
        idle();
        serve_wait();
        check("serve_after_reset", 8'(serve), 8'd1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 599) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 79) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
